// File: rtl/lemming_world.sv
// Terrain environment for the lemming walker FSM: tracks the lemming's column,
// generates bump/ground feedback to the FSM and detects fatal falls (splat).
module lemming_world #(
  parameter int WIDTH       = 16,
  parameter int POS_W       = 4,
  parameter int START_POS   = 8,
  parameter int STEP_DIV    = 4,
  parameter int FC_W        = 5,
  parameter int SPLAT_LIMIT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aaah,
  input  logic [WIDTH-1:0] ground_map,
  input  logic [WIDTH-1:0] wall_map,
  output logic             bump_left,
  output logic             bump_right,
  output logic             ground,
  output logic [POS_W-1:0] pos,
  output logic [FC_W-1:0]  fall_cnt,
  output logic             splat,
  output logic             proto_err
);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int               SC_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SC_W-1:0]  STEP_LAST = SC_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] START_P   = POS_W'(START_POS);
  localparam logic [FC_W-1:0]  FC_MAX    = '1;

  logic [SC_W-1:0]  step_cnt, step_nxt, step_eff;
  logic [POS_W-1:0] pos_nxt, pos_m1, pos_p1;
  logic [FC_W-1:0]  fall_nxt;
  logic             splat_nxt, proto_nxt;
  dir_e             dir_q, dir_nxt, dir_cur;
  logic             blk_l, blk_r, blocked, walking;

  // Neighbour lookups; the guarded index is only used when it is in range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    pos_m1 = pos - 1'b1;
    pos_p1 = pos + 1'b1;
    blk_l  = 1'b1;
    blk_r  = 1'b1;
    if (pos != '0)       blk_l = wall_map[pos_m1];
    if (pos != LAST_POS) blk_r = wall_map[pos_p1];
  end

  assign bump_left  = walk_left  & blk_l & ~splat;
  assign bump_right = walk_right & blk_r & ~splat;
  assign ground     = ground_map[pos] | splat;

  assign walking = (walk_left ^ walk_right) & ~aaah & ~splat;
  assign dir_cur = walk_right ? DIR_RIGHT : DIR_LEFT;
  assign blocked = (dir_cur == DIR_RIGHT) ? blk_r : blk_l;
  // A direction change restarts the step count, and this cycle counts as the
  // first walking cycle of the new direction.
  assign step_eff = (dir_cur != dir_q) ? '0 : step_cnt;

  always_comb begin
    pos_nxt   = pos;
    step_nxt  = step_cnt;
    fall_nxt  = fall_cnt;
    splat_nxt = splat;
    dir_nxt   = dir_q;
    proto_nxt = proto_err | (walk_left & walk_right & ~aaah);

    if (!splat) begin
      if (walking) begin
        dir_nxt = dir_cur;
        if (step_eff == STEP_LAST) begin
          step_nxt = '0;
          if (!blocked) pos_nxt = (dir_cur == DIR_RIGHT) ? pos_p1 : pos_m1;
        end else begin
          step_nxt = step_eff + 1'b1;
        end
      end else begin
        step_nxt = '0;
      end

      if (aaah) begin
        if (!ground) begin
          fall_nxt = (fall_cnt == FC_MAX) ? fall_cnt : fall_cnt + 1'b1;
        end else begin
          fall_nxt = '0;
          if (int'(fall_cnt) >= SPLAT_LIMIT) splat_nxt = 1'b1;
        end
      end else begin
        fall_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pos       <= START_P;
      step_cnt  <= '0;
      fall_cnt  <= '0;
      splat     <= 1'b0;
      proto_err <= 1'b0;
      dir_q     <= DIR_LEFT;
    end else begin
      pos       <= pos_nxt;
      step_cnt  <= step_nxt;
      fall_cnt  <= fall_nxt;
      splat     <= splat_nxt;
      proto_err <= proto_nxt;
      dir_q     <= dir_nxt;
    end
  end

endmodule
